// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file write arbiter.
package wb_pkg;

    localparam int              XLEN_DEF   = 32;
    localparam int              REG_ADDR_W = 5;
    localparam logic [4:0]      ZERO_REG   = 5'd0;

    // One long-result buffer entry at the default data width.
    typedef struct packed {
        logic                   live;
        logic [REG_ADDR_W-1:0]  rd;
        logic [XLEN_DEF-1:0]    data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer for long-latency results with per-entry live bits,
// kill-by-destination and two read-address snoop ports.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [REG_ADDR_W-1:0]    i_push_rd,
    input  logic [XLEN-1:0]          i_push_data,
    input  logic                     i_pop,
    input  logic                     i_kill_en,
    input  logic [REG_ADDR_W-1:0]    i_kill_rd,
    input  logic [REG_ADDR_W-1:0]    i_snoop_rd1,
    input  logic [REG_ADDR_W-1:0]    i_snoop_rd2,
    output logic                     o_snoop_hit1,
    output logic                     o_snoop_hit2,
    output logic                     o_head_live,
    output logic [REG_ADDR_W-1:0]    o_head_rd,
    output logic [XLEN-1:0]          o_head_data,
    output logic [$clog2(DEPTH):0]   o_occupancy,
    output logic                     o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic                   r_live [DEPTH];
    logic [REG_ADDR_W-1:0]  r_rd   [DEPTH];
    logic [XLEN-1:0]        r_data [DEPTH];
    logic [AW-1:0]          r_wr_ptr;
    logic [AW-1:0]          r_rd_ptr;
    logic [CW-1:0]          r_count;

    // Storage, pointers and count; a popped slot loses its live bit so
    // stale contents can never produce a snoop hit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_live[i] <= 1'b0;
                r_rd[i]   <= ZERO_REG;
                r_data[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i_kill_en && r_live[i] && (r_rd[i] == i_kill_rd))
                    r_live[i] <= 1'b0;
            end
            if (i_pop) begin
                r_live[r_rd_ptr] <= 1'b0;
                r_rd_ptr         <= r_rd_ptr + AW'(1);
            end
            if (i_push) begin
                r_live[r_wr_ptr] <= 1'b1;
                r_rd[r_wr_ptr]   <= i_push_rd;
                r_data[r_wr_ptr] <= i_push_data;
                r_wr_ptr         <= r_wr_ptr + AW'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Snoop: any live entry whose destination matches the read address.
    always_comb begin
        o_snoop_hit1 = 1'b0;
        o_snoop_hit2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_live[i] && (r_rd[i] == i_snoop_rd1)) o_snoop_hit1 = 1'b1;
            if (r_live[i] && (r_rd[i] == i_snoop_rd2)) o_snoop_hit2 = 1'b1;
        end
    end

    assign o_head_live = r_live[r_rd_ptr];
    assign o_head_rd   = r_rd[r_rd_ptr];
    assign o_head_data = r_data[r_rd_ptr];
    assign o_occupancy = r_count;
    assign o_empty     = (r_count == '0);

endmodule

// File: rtl/reg_write_arbiter.sv
// Merges the non-stallable pipeline writeback and the long-latency unit
// into the register file's single write port, with pending-write snooping.
// Optional macro WB_FWD_EN: output-stage hits are forwarded instead of
// raising pendHit.
module reg_write_arbiter
    import wb_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     pipeValid,
    input  logic [REG_ADDR_W-1:0]    pipeRd,
    input  logic [XLEN-1:0]          pipeData,
    input  logic                     lngValid,
    output logic                     lngReady,
    input  logic [REG_ADDR_W-1:0]    lngRd,
    input  logic [XLEN-1:0]          lngData,
    input  logic [REG_ADDR_W-1:0]    readReg1,
    input  logic [REG_ADDR_W-1:0]    readReg2,
    output logic                     pendHit1,
    output logic                     pendHit2,
`ifdef WB_FWD_EN
    output logic                     fwdValid1,
    output logic                     fwdValid2,
    output logic [XLEN-1:0]          fwdData1,
    output logic [XLEN-1:0]          fwdData2,
`endif
    output logic                     writeCntrl,
    output logic [REG_ADDR_W-1:0]    writeAd,
    output logic [XLEN-1:0]          data,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic                   w_pipe_wr;
    logic                   w_lng_xfer;
    logic                   w_lng_keep;
    logic                   w_pop;
    logic                   w_bypass;
    logic                   w_push;
    logic                   w_empty;
    logic                   w_head_live;
    logic [REG_ADDR_W-1:0]  w_head_rd;
    logic [XLEN-1:0]        w_head_data;
    logic                   w_buf_hit1;
    logic                   w_buf_hit2;
    logic                   w_out_hit1;
    logic                   w_out_hit2;
    logic                   w_nxt_we;
    logic [REG_ADDR_W-1:0]  w_nxt_ad;
    logic [XLEN-1:0]        w_nxt_data;
    logic                   r_we;
    logic [REG_ADDR_W-1:0]  r_ad;
    logic [XLEN-1:0]        r_data;

    // Ready depends only on registered occupancy, so a full buffer refuses a
    // transfer even in a cycle where it also pops.
    assign lngReady   = (occupancy < CW'(DEPTH));
    assign w_pipe_wr  = pipeValid && (pipeRd != ZERO_REG);
    assign w_lng_xfer = lngValid && lngReady;
    // x0 results are swallowed; a same-rd pipe write is younger and wins.
    assign w_lng_keep = w_lng_xfer && (lngRd != ZERO_REG) &&
                        !(w_pipe_wr && (pipeRd == lngRd));
    assign w_pop      = !w_pipe_wr && !w_empty;
    assign w_bypass   = !w_pipe_wr && w_empty && w_lng_keep;
    assign w_push     = w_lng_keep && !w_bypass;

    wb_fifo #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_push       (w_push),
        .i_push_rd    (lngRd),
        .i_push_data  (lngData),
        .i_pop        (w_pop),
        .i_kill_en    (w_pipe_wr),
        .i_kill_rd    (pipeRd),
        .i_snoop_rd1  (readReg1),
        .i_snoop_rd2  (readReg2),
        .o_snoop_hit1 (w_buf_hit1),
        .o_snoop_hit2 (w_buf_hit2),
        .o_head_live  (w_head_live),
        .o_head_rd    (w_head_rd),
        .o_head_data  (w_head_data),
        .o_occupancy  (occupancy),
        .o_empty      (w_empty)
    );

    // Write-port priority: pipe, then buffer head, then long bypass.
    always_comb begin
        w_nxt_we   = 1'b0;
        w_nxt_ad   = ZERO_REG;
        w_nxt_data = '0;
        if (w_pipe_wr) begin
            w_nxt_we   = 1'b1;
            w_nxt_ad   = pipeRd;
            w_nxt_data = pipeData;
        end else if (w_pop) begin
            if (w_head_live) begin
                w_nxt_we   = 1'b1;
                w_nxt_ad   = w_head_rd;
                w_nxt_data = w_head_data;
            end
        end else if (w_bypass) begin
            w_nxt_we   = 1'b1;
            w_nxt_ad   = lngRd;
            w_nxt_data = lngData;
        end
    end

    // Registered write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we   <= 1'b0;
            r_ad   <= ZERO_REG;
            r_data <= '0;
        end else begin
            r_we   <= w_nxt_we;
            r_ad   <= w_nxt_ad;
            r_data <= w_nxt_data;
        end
    end

    assign writeCntrl = r_we;
    assign writeAd    = r_ad;
    assign data       = r_data;

    assign w_out_hit1 = r_we && (r_ad == readReg1);
    assign w_out_hit2 = r_we && (r_ad == readReg2);

`ifdef WB_FWD_EN
    // Output-stage-only hits are forwarded; buffered hits still stall.
    assign pendHit1  = (readReg1 != ZERO_REG) && w_buf_hit1;
    assign pendHit2  = (readReg2 != ZERO_REG) && w_buf_hit2;
    assign fwdValid1 = (readReg1 != ZERO_REG) && w_out_hit1 && !w_buf_hit1;
    assign fwdValid2 = (readReg2 != ZERO_REG) && w_out_hit2 && !w_buf_hit2;
    assign fwdData1  = r_data;
    assign fwdData2  = r_data;
`else
    // A write in the output stage lands next edge, so it also stalls decode.
    assign pendHit1 = (readReg1 != ZERO_REG) && (w_buf_hit1 || w_out_hit1);
    assign pendHit2 = (readReg2 != ZERO_REG) && (w_buf_hit2 || w_out_hit2);
`endif

endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
- Merges two producers into the register file's single write port (`data`/`writeAd`/`writeCntrl`).
  - The in-order pipeline writeback cannot be stalled.
  - The long-latency unit (mul/div) uses a valid/ready handshake.
- Long results are buffered until the port is free.
- Snoops the decode-stage read addresses (`readReg1`/`readReg2`) and flags pending writes so decode can stall.
- Sits directly upstream of the register file.

Parameters:
- `XLEN`, 32, data width.
- `DEPTH`, 4, long-result buffer entries; power of two, ≥2.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `pipeValid`  in  1  pipeline result present this cycle; always accepted.
- `pipeRd`  in  5  pipeline destination register.
- `pipeData`  in  XLEN  pipeline result.
- `lngValid`  in  1  long-unit result offered.
- `lngReady`  out  1  arbiter can accept a long result.
- `lngRd`  in  5  long-unit destination register.
- `lngData`  in  XLEN  long-unit result.
- `readReg1`  in  5  decode read address 1 (snooped).
- `readReg2`  in  5  decode read address 2 (snooped).
- `pendHit1`  out  1  a pending write targets `readReg1`.
- `pendHit2`  out  1  a pending write targets `readReg2`.
- `writeCntrl`  out  1  register file write enable (registered).
- `writeAd`  out  5  register file write address (registered).
- `data`  out  XLEN  register file write data (registered).
- `occupancy`  out  $clog2(DEPTH)+1  live + killed entries held in the buffer.

Behaviour:
- **Reset** (async, `rst_n`=0):
  - `writeCntrl`=0, `writeAd`=0, `data`=0.
  - Buffer empty, `occupancy`=0; `lngReady`=1 after reset.
  - Any in-flight buffered results are discarded; no write is issued during reset.
- **Output stage** is a register; every write reaches `writeCntrl`/`writeAd`/`data` exactly 1 cycle after its source cycle.
- **Per-cycle priority:**
  1. `pipeValid` && `pipeRd`!=0 → output loads pipe result.
  2. Else buffer non-empty → pop head.
     - If the head is live, output loads it.
     - If it is killed, it pops with `writeCntrl`=0.
  3. Else the long result accepted this cycle bypasses the buffer straight to the output (latency 1).
  4. Else `writeCntrl`=0.
- **Long handshake:**
  - `lngReady` = (`occupancy` < DEPTH), computed from registered state only; no push when full even if a pop occurs that cycle.
  - Transfer occurs when `lngValid` && `lngReady`.
  - `lngRd`==0 is accepted and dropped (no entry, no write).
  - A transfer not bypassed is pushed at the tail.
- **x0:** pipe result with `pipeRd`==0 is ignored, which frees the port for the buffer that cycle. `writeAd`=0 with `writeCntrl`=1 never occurs.
- **WAW kill:** a pipe write to rd (nonzero) clears the live bit of every buffered entry with the same rd. If a long transfer with the same rd occurs in the same cycle, that long result is discarded; the pipe instruction is younger.
- **Ordering:** buffered entries drain strictly FIFO.
- **Pointers:** `$clog2(DEPTH)` bits, wrapping naturally.
  - `occupancy` counts entries, including killed ones.
  - Simultaneous push+pop leaves `occupancy` unchanged.
- **pendHit[n]** (combinational) is 1 when `readReg[n]`!=0 and it matches either:
  - any live buffer entry, or
  - `writeAd` while `writeCntrl`=1 (write lands at the next edge).

Optional Feature:
- Macro `WB_FWD_EN`.
- **Defined:** adds outputs `fwdValid1`/`fwdValid2` (1) and `fwdData1`/`fwdData2` (XLEN).
  - When the only hit is the output stage (`writeAd`==`readReg[n]`, `writeCntrl`=1), `fwdValid[n]`=1, `fwdData[n]`=`data`, and `pendHit[n]`=0.
  - Buffer hits still raise `pendHit`.
- **Undefined:** no forwarding ports; `pendHit` behaves as specified above.

Decomposition:
- Package `wb_pkg`: `XLEN` default, `REG_ADDR_W`=5, `ZERO_REG`=5'd0, a buffer entry struct {`live`, `rd`, `data`}.
- Sub-module `wb_fifo`:
  - circular buffer with per-entry live bits;
  - kill-by-rd input;
  - two snoop compare ports;
  - push/pop/`occupancy`.
- Arbitration and the output register stay in `reg_write_arbiter`.

Test Plan:
1. **Reset:** assert `rst_n`=0 mid-stream with 2 buffered entries → outputs 0 immediately; `occupancy`=0 and `lngReady`=1 after release; no stale writes follow.
2. **Bypass:** `pipeValid`=0, buffer empty, long rd=7 data=0x1234 → next cycle `writeCntrl`=1, `writeAd`=7, `data`=0x1234; `occupancy` stays 0.
3. **Buffering and fill:** hold `pipeValid`=1 (rd=3..) while pushing long rd=10..13 → `occupancy` reaches 4, `lngReady`=0. Drop `pipeValid` → writes 10,11,12,13 on consecutive cycles in order.
4. **x0:** `pipeValid`=1 with `pipeRd`=0 while the buffer holds rd=5 → rd=5 written next cycle. Long transfer with rd=0 → no write, `occupancy` unchanged.
5. **WAW kill:** buffer holds rd=9 (0xAAAA); pipe writes rd=9 (0xBBBB) → only 0xBBBB is written; the killed entry later pops with `writeCntrl`=0.
6. **Snoop:** buffer holds rd=4; `readReg1`=4, `readReg2`=0 → `pendHit1`=1, `pendHit2`=0.
   - With `WB_FWD_EN` and only the output stage writing rd=4 → `fwdValid1`=1, `pendHit1`=0.
